halfword_narrower: RTL and testbench

//   Narrowing serializer: the inverse direction of the 16->32 immediate extender.
//   - Accepts 32-bit words over a valid/ready handshake.
//   - Emits them as 16-bit halfwords on a second valid/ready handshake.
//   - If the upper half is a pure sign/zero extension of the lower half (per SignExt),

---
 rtl/halfword_narrower.sv | 148 ++++++++++++++
 tb/tb_halfword_narrower.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/halfword_narrower.sv
`default_nettype none
// ============================================================================
// Module      : halfword_narrower
// Description : Narrowing serializer. Accepts 32-bit words on a valid/ready
//               handshake and emits them as 16-bit halfwords on a second
//               valid/ready handshake. A word whose upper half is a pure
//               sign/zero extension of its lower half is sent as a single
//               compressed halfword. Any other word is sent as the low half
//               followed by the high half.
// Ports       : CLK, Reset_n (async, active low)
//               InValid/InReady/InData[31:0]/InSign   - word input
//               OutValid/OutReady/OutData[15:0]       - halfword output
//               OutLast/OutComp/OutSign               - per-beat side info
//               ClrCnt, WordCnt, CompCnt              - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module halfword_narrower #(
    parameter int COMPRESS = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      InData,
    input  logic             InSign,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [15:0]      OutData,
    output logic             OutLast,
    output logic             OutComp,
    output logic             OutSign,
    input  logic             ClrCnt,
    output logic [CNT_W-1:0] WordCnt,
    output logic [CNT_W-1:0] CompCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        SEND_C  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_n;
    logic [15:0] hi_hold, hi_hold_n;
    logic [15:0] data_n;
    logic        valid_n, last_n, comp_n, sign_n;
    logic        accept, beat, fit;

    // Ready depends only on state and the sink, never on InValid, so no
    // combinational loop can form through an upstream that waits on ready.
    // In every non-IDLE state OutValid is 1, so a last beat frees the slot.
    always_comb begin
        InReady = (state == IDLE) | (OutValid & OutReady & OutLast);
        accept  = InValid & InReady;
        beat    = OutValid & OutReady;
        if (COMPRESS == 0)
            fit = 1'b0;
        else if (InSign)
            fit = (InData[31:16] == {16{InData[15]}});
        else
            fit = (InData[31:16] == 16'h0000);
    end

    always_comb begin
        // Hold everything by default; this is what keeps outputs stable
        // during a stall.
        state_n   = state;
        hi_hold_n = hi_hold;
        data_n    = OutData;
        valid_n   = OutValid;
        last_n    = OutLast;
        comp_n    = OutComp;
        sign_n    = OutSign;

        unique case (state)
            IDLE: ;
            SEND_LO: begin
                if (beat) begin
                    state_n = SEND_HI;
                    data_n  = hi_hold;
                    last_n  = 1'b1;
                end
            end
            SEND_HI, SEND_C: begin
                if (beat && !accept) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // A new word can be loaded from IDLE or on the last beat of the
        // previous word (no bubble). accept already encodes both cases.
        if (accept) begin
            state_n   = fit ? SEND_C : SEND_LO;
            hi_hold_n = InData[31:16];
            data_n    = InData[15:0];
            valid_n   = 1'b1;
            last_n    = fit;
            comp_n    = fit;
            sign_n    = InSign;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            hi_hold  <= 16'h0000;
            OutData  <= 16'h0000;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            OutComp  <= 1'b0;
            OutSign  <= 1'b0;
        end else begin
            state    <= state_n;
            hi_hold  <= hi_hold_n;
            OutData  <= data_n;
            OutValid <= valid_n;
            OutLast  <= last_n;
            OutComp  <= comp_n;
            OutSign  <= sign_n;
        end
    end

    // Statistics: clear has priority over a same-cycle accept.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            WordCnt <= '0;
            CompCnt <= '0;
        end else if (ClrCnt) begin
            WordCnt <= '0;
            CompCnt <= '0;
        end else begin
            if (accept && (WordCnt != CNT_MAX))
                WordCnt <= WordCnt + CNT_ONE;
            if (accept && fit && (CompCnt != CNT_MAX))
                CompCnt <= CompCnt + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_halfword_narrower.sv
`default_nettype none
// ============================================================================
// Module      : tb_halfword_narrower
// Description : Directed self-checking bench for halfword_narrower. One
//               instance with compression and 16-bit counters, one with
//               compression disabled and 3-bit counters for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halfword_narrower;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;

    logic        InValid = 1'b0, InSign = 1'b0, OutReady = 1'b0, ClrCnt = 1'b0;
    logic [31:0] InData = '0;
    logic        InReady, OutValid, OutLast, OutComp, OutSign;
    logic [15:0] OutData;
    logic [15:0] WordCnt, CompCnt;

    logic        in_valid2 = 1'b0, in_sign2 = 1'b0, out_ready2 = 1'b0, clr2 = 1'b0;
    logic [31:0] in_data2 = '0;
    logic        in_ready2, out_valid2, out_last2, out_comp2, out_sign2;
    logic [15:0] out_data2;
    logic [2:0]  word_cnt2, comp_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    halfword_narrower #(.COMPRESS(1), .CNT_W(16)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .InValid(InValid), .InReady(InReady), .InData(InData), .InSign(InSign),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutLast(OutLast), .OutComp(OutComp), .OutSign(OutSign),
        .ClrCnt(ClrCnt), .WordCnt(WordCnt), .CompCnt(CompCnt)
    );

    halfword_narrower #(.COMPRESS(0), .CNT_W(3)) dut2 (
        .CLK(CLK), .Reset_n(Reset_n),
        .InValid(in_valid2), .InReady(in_ready2), .InData(in_data2), .InSign(in_sign2),
        .OutValid(out_valid2), .OutReady(out_ready2), .OutData(out_data2),
        .OutLast(out_last2), .OutComp(out_comp2), .OutSign(out_sign2),
        .ClrCnt(clr2), .WordCnt(word_cnt2), .CompCnt(comp_cnt2)
    );

    // Advance one clock; inputs are changed and outputs sampled 1ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) step();
        tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", OutValid); end
        tests++; if (OutData !== 16'h0000) begin fails++; $display("FAIL rst_data got %h exp 0000", OutData); end
        tests++; if ({OutLast, OutComp, OutSign} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b exp 000", {OutLast, OutComp, OutSign}); end
        tests++; if (WordCnt !== 16'd0 || CompCnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", WordCnt, CompCnt); end
        Reset_n = 1'b1;
        step();
        tests++; if (InReady !== 1'b1) begin fails++; $display("FAIL rst_inready got %b exp 1", InReady); end
        tests++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin fails++; $display("FAIL rst_dut2 got v=%b r=%b exp v=0 r=1", out_valid2, in_ready2); end
    endtask

    task automatic test_compressed();
        OutReady = 1'b1; InSign = 1'b1; InData = 32'hFFFF_8001; InValid = 1'b1;
        step();
        InValid = 1'b0;
        tests++; if (OutValid !== 1'b1 || OutData !== 16'h8001) begin fails++; $display("FAIL comp_data got v=%b %h exp v=1 8001", OutValid, OutData); end
        tests++; if ({OutLast, OutComp, OutSign} !== 3'b111) begin fails++; $display("FAIL comp_flags got %b exp 111", {OutLast, OutComp, OutSign}); end
        tests++; if (CompCnt !== 16'd1 || WordCnt !== 16'd1) begin fails++; $display("FAIL comp_cnt got %0d/%0d exp 1/1", WordCnt, CompCnt); end
        step();
        tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL comp_idle got %b exp 0", OutValid); end
    endtask

    task automatic test_two_beats();
        InSign = 1'b0; InData = 32'hFFFF_8001; InValid = 1'b1;
        step();
        InValid = 1'b0;
        tests++; if (OutData !== 16'h8001 || {OutLast, OutComp, OutSign} !== 3'b000) begin fails++; $display("FAIL two_lo got %h %b exp 8001 000", OutData, {OutLast, OutComp, OutSign}); end
        tests++; if (InReady !== 1'b0) begin fails++; $display("FAIL two_inready got %b exp 0", InReady); end
        step();
        tests++; if (OutValid !== 1'b1 || OutData !== 16'hFFFF || {OutLast, OutComp} !== 2'b10) begin fails++; $display("FAIL two_hi got v=%b %h %b exp v=1 ffff 10", OutValid, OutData, {OutLast, OutComp}); end
        step();
        tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL two_idle got %b exp 0", OutValid); end
        tests++; if (WordCnt !== 16'd2 || CompCnt !== 16'd1) begin fails++; $display("FAIL two_cnt got %0d/%0d exp 2/1", WordCnt, CompCnt); end
    endtask

    task automatic test_stall();
        InSign = 1'b0; InData = 32'h1234_5678; InValid = 1'b1; OutReady = 1'b0;
        step();
        InValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (OutValid !== 1'b1 || OutData !== 16'h5678 || OutLast !== 1'b0 || InReady !== 1'b0) begin
                fails++; $display("FAIL stall_hold[%0d] got v=%b %h l=%b r=%b exp v=1 5678 l=0 r=0", i, OutValid, OutData, OutLast, InReady);
            end
        end
        OutReady = 1'b1;
        step();
        tests++; if (OutValid !== 1'b1 || OutData !== 16'h1234 || OutLast !== 1'b1) begin fails++; $display("FAIL stall_hi got v=%b %h l=%b exp v=1 1234 l=1", OutValid, OutData, OutLast); end
        tests++; if (InReady !== 1'b1) begin fails++; $display("FAIL stall_inready got %b exp 1", InReady); end
        step();
        tests++; if (OutValid !== 1'b0 || WordCnt !== 16'd3) begin fails++; $display("FAIL stall_end got v=%b cnt=%0d exp v=0 cnt=3", OutValid, WordCnt); end
    endtask

    task automatic test_back_to_back();
        OutReady = 1'b1; InSign = 1'b0; InData = 32'h0000_0005; InValid = 1'b1;
        step();
        tests++; if (OutData !== 16'h0005 || OutComp !== 1'b1 || InReady !== 1'b1) begin fails++; $display("FAIL b2b_first got %h c=%b r=%b exp 0005 c=1 r=1", OutData, OutComp, InReady); end
        InData = 32'h0000_0007;
        step();
        InValid = 1'b0;
        tests++; if (OutValid !== 1'b1 || OutData !== 16'h0007 || OutComp !== 1'b1) begin fails++; $display("FAIL b2b_second got v=%b %h c=%b exp v=1 0007 c=1", OutValid, OutData, OutComp); end
        step();
        tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b exp 0", OutValid); end
        tests++; if (WordCnt !== 16'd5 || CompCnt !== 16'd3) begin fails++; $display("FAIL b2b_cnt got %0d/%0d exp 5/3", WordCnt, CompCnt); end
    endtask

    task automatic test_reset_mid_word();
        OutReady = 1'b1; InSign = 1'b0; InData = 32'h1234_5678; InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        tests++; if (OutData !== 16'h1234 || OutLast !== 1'b1) begin fails++; $display("FAIL rmid_hi got %h l=%b exp 1234 l=1", OutData, OutLast); end
        OutReady = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        tests++; if (OutValid !== 1'b0 || OutData !== 16'h0000) begin fails++; $display("FAIL rmid_async got v=%b %h exp v=0 0000", OutValid, OutData); end
        tests++; if (WordCnt !== 16'd0 || CompCnt !== 16'd0) begin fails++; $display("FAIL rmid_cnt got %0d/%0d exp 0/0", WordCnt, CompCnt); end
        step();
        Reset_n = 1'b1;
        OutReady = 1'b1;
        step();
        step();
        tests++; if (OutValid !== 1'b0) begin fails++; $display("FAIL rmid_nobeat got %b exp 0", OutValid); end
        InData = 32'h0000_0005; InValid = 1'b1;
        step();
        InValid = 1'b0;
        tests++; if (OutData !== 16'h0005 || OutComp !== 1'b1 || WordCnt !== 16'd1) begin fails++; $display("FAIL rmid_next got %h c=%b cnt=%0d exp 0005 c=1 cnt=1", OutData, OutComp, WordCnt); end
        step();
    endtask

    task automatic test_no_compress();
        out_ready2 = 1'b1; in_sign2 = 1'b0; in_data2 = 32'h0000_0000; in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        tests++; if (out_valid2 !== 1'b1 || out_data2 !== 16'h0000 || {out_last2, out_comp2} !== 2'b00) begin fails++; $display("FAIL nc_lo got v=%b %h %b exp v=1 0000 00", out_valid2, out_data2, {out_last2, out_comp2}); end
        step();
        tests++; if (out_valid2 !== 1'b1 || out_data2 !== 16'h0000 || {out_last2, out_comp2} !== 2'b10) begin fails++; $display("FAIL nc_hi got v=%b %h %b exp v=1 0000 10", out_valid2, out_data2, {out_last2, out_comp2}); end
        step();
        tests++; if (out_valid2 !== 1'b0 || word_cnt2 !== 3'd1 || comp_cnt2 !== 3'd0) begin fails++; $display("FAIL nc_end got v=%b cnt=%0d/%0d exp v=0 1/0", out_valid2, word_cnt2, comp_cnt2); end
    endtask

    task automatic test_saturate_clear();
        bit seen;
        out_ready2 = 1'b1; in_data2 = 32'hABCD_0001; in_valid2 = 1'b1;
        // About ten more accepts: far beyond the 3-bit limit.
        repeat (20) step();
        tests++; if (word_cnt2 !== 3'd7 || comp_cnt2 !== 3'd0) begin fails++; $display("FAIL sat_cnt got %0d/%0d exp 7/0", word_cnt2, comp_cnt2); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready2) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        tests++; if (!seen) begin fails++; $display("FAIL clr_wait got in_ready=0 exp 1 within 4 cycles"); end
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        in_valid2 = 1'b0;
        tests++; if (word_cnt2 !== 3'd0) begin fails++; $display("FAIL clr_wins got %0d exp 0", word_cnt2); end
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_two_beats();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_no_compress();
        test_saturate_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
